// File: rtl/sobel_pkg.sv
// Shared types and helpers for the 3x3 Sobel edge stage: window type,
// gradient width, pipeline latency and the small arithmetic helpers.
package sobel_pkg;

    localparam int DW_DEF = 8;
    localparam int GW     = DW_DEF + 3;
    localparam int LAT    = 4;

    typedef logic [DW_DEF-1:0] pix_t;

    // win[row][col]: row 0 is the oldest line, col 0 the oldest column
    typedef logic [2:0][2:0][DW_DEF-1:0] win_t;

    // a + 2b + c, widened to the signed gradient width
    function automatic logic signed [GW-1:0] wsum(input pix_t a, input pix_t b, input pix_t c);
        logic signed [GW-1:0] ea;
        logic signed [GW-1:0] eb;
        logic signed [GW-1:0] ec;
        ea = $signed({3'b000, a});
        eb = $signed({2'b00, b, 1'b0});
        ec = $signed({3'b000, c});
        return ea + eb + ec;
    endfunction

    function automatic logic [GW-1:0] abs_gw(input logic signed [GW-1:0] v);
        logic [GW-1:0] u;
        u = v;
        return v[GW-1] ? (~u + {{(GW-1){1'b0}}, 1'b1}) : u;
    endfunction

endpackage

// File: rtl/sobel_window.sv
// 3x3 window former: column shift register, column/line counters, vsync
// edge detect and the window-valid flag that travels with stage 1.
module sobel_window
    import sobel_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int IMG_W = 1280
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            de_i,
    input  logic            vsync_i,
    input  logic [3*DW-1:0] col_i,
    output win_t            win_o,
    output logic            win_ok_o
);

    localparam int          CW      = $clog2(IMG_W);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);

    win_t          win_q, win_d;
    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic [1:0]    line_cnt_q, line_cnt_d;
    logic          lock_q, lock_d;
    logic          de_q;
    logic          vs_q;
    logic          win_ok_q, win_ok_d;
    logic          vs_fall_s;
    logic          de_fall_s;

    assign vs_fall_s = vs_q & ~vsync_i;
    assign de_fall_s = de_q & ~de_i;

    // Window shift, counters and validity; lock_q keeps output blank until a
    // full frame start has been seen after reset.
    always_comb begin
        win_d      = win_q;
        col_cnt_d  = col_cnt_q;
        line_cnt_d = line_cnt_q;
        lock_d     = lock_q;
        if (de_i) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
                win_d[r][2] = col_i[(2-r)*DW +: DW];
            end
            col_cnt_d = (col_cnt_q == COL_MAX) ? col_cnt_q : col_cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            col_cnt_d = '0;
        end
        if (vs_fall_s) begin
            line_cnt_d = 2'd0;
            lock_d     = 1'b1;
        end else if (de_fall_s && (line_cnt_q != 2'd3)) begin
            line_cnt_d = line_cnt_q + 2'd1;
        end else begin
            line_cnt_d = line_cnt_q;
        end
        win_ok_d = de_i & (col_cnt_q >= CW'(2)) & (line_cnt_q >= 2'd2) & lock_q;
    end

    // State registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            win_q      <= '0;
            col_cnt_q  <= '0;
            line_cnt_q <= 2'd0;
            lock_q     <= 1'b0;
            de_q       <= 1'b0;
            vs_q       <= 1'b0;
            win_ok_q   <= 1'b0;
        end else begin
            win_q      <= win_d;
            col_cnt_q  <= col_cnt_d;
            line_cnt_q <= line_cnt_d;
            lock_q     <= lock_d;
            de_q       <= de_i;
            vs_q       <= vsync_i;
            win_ok_q   <= win_ok_d;
        end
    end

    assign win_o    = win_q;
    assign win_ok_o = win_ok_q;

endmodule

// File: rtl/sobel_3x3.sv
// Sobel |Gx|+|Gy| edge stage, four clocks from column in to pixel out.
// Define SOBEL_THRESH_EN to emit a binary edge map (mag >= THRESH -> all ones).
module sobel_3x3
    import sobel_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int IMG_W  = 1280,
    parameter int THRESH = 128
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            i_hsync,
    input  logic            i_vsync,
    input  logic            i_de,
    input  logic [3*DW-1:0] i_col,
    output logic            o_hsync,
    output logic            o_vsync,
    output logic            o_de,
    output logic [DW-1:0]   o_data
);

    win_t                 win_s;
    logic                 ok1_s;
    logic signed [GW-1:0] gx_q, gx_d;
    logic signed [GW-1:0] gy_q, gy_d;
    logic                 ok2_q;
    logic [GW-1:0]        mag_q, mag_d;
    logic                 ok3_q;
    logic [DW-1:0]        data_q, data_d;
    logic [LAT-1:0][2:0]  sync_q;

    sobel_window #(
        .DW    (DW),
        .IMG_W (IMG_W)
    ) u_window (
        .clk      (clk),
        .nrst     (nrst),
        .de_i     (i_de),
        .vsync_i  (i_vsync),
        .col_i    (i_col),
        .win_o    (win_s),
        .win_ok_o (ok1_s)
    );

    // S2 gradients, S3 magnitude, S4 output pixel
    always_comb begin
        gx_d = wsum(win_s[0][2], win_s[1][2], win_s[2][2]) - wsum(win_s[0][0], win_s[1][0], win_s[2][0]);
        gy_d = wsum(win_s[2][0], win_s[2][1], win_s[2][2]) - wsum(win_s[0][0], win_s[0][1], win_s[0][2]);
        mag_d = abs_gw(gx_q) + abs_gw(gy_q);
`ifdef SOBEL_THRESH_EN
        if (ok3_q && (mag_q >= GW'(THRESH))) begin
            data_d = {DW{1'b1}};
        end else begin
            data_d = {DW{1'b0}};
        end
`else
        if (!ok3_q) begin
            data_d = {DW{1'b0}};
        end else if (|mag_q[GW-1:DW]) begin
            data_d = {DW{1'b1}};
        end else begin
            data_d = mag_q[DW-1:0];
        end
`endif
    end

    // Arithmetic pipeline and sync delay line advance together every clock
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            gx_q   <= '0;
            gy_q   <= '0;
            ok2_q  <= 1'b0;
            mag_q  <= '0;
            ok3_q  <= 1'b0;
            data_q <= '0;
            sync_q <= '0;
        end else begin
            gx_q   <= gx_d;
            gy_q   <= gy_d;
            ok2_q  <= ok1_s;
            mag_q  <= mag_d;
            ok3_q  <= ok2_q;
            data_q <= data_d;
            sync_q <= {sync_q[LAT-2:0], i_hsync, i_vsync, i_de};
        end
    end

    assign o_hsync = sync_q[LAT-1][2];
    assign o_vsync = sync_q[LAT-1][1];
    assign o_de    = sync_q[LAT-1][0];
    assign o_data  = data_q;

endmodule

// File: tb/tb_sobel_3x3.sv
// Directed bench for sobel_3x3: hand-computed magnitudes per test line,
// outputs checked every cycle against inputs delayed by four clocks.
module tb_sobel_3x3;

    localparam int IMG_W  = 1280;
    localparam int THRESH = 128;

    localparam int P_FLAT    = 0;
    localparam int P_STEP10  = 1;
    localparam int P_STEP100 = 2;
    localparam int P_FALL10  = 3;
    localparam int P_HORIZ   = 4;
    localparam int P_CORNER  = 5;
    localparam int P_STEP30  = 6;
    localparam int P_STEP40  = 7;

    logic        clk = 1'b0;
    logic        nrst;
    logic        i_hsync;
    logic        i_vsync;
    logic        i_de;
    logic [23:0] i_col;
    logic        o_hsync;
    logic        o_vsync;
    logic        o_de;
    logic [7:0]  o_data;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sobel_3x3 #(
        .DW     (8),
        .IMG_W  (IMG_W),
        .THRESH (THRESH)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .i_hsync (i_hsync),
        .i_vsync (i_vsync),
        .i_de    (i_de),
        .i_col   (i_col),
        .o_hsync (o_hsync),
        .o_vsync (o_vsync),
        .o_de    (o_de),
        .o_data  (o_data)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix(input int pat, input int row, input int c);
        case (pat)
            P_FLAT:    return 8'd50;
            P_STEP10:  return (c >= 640) ? 8'd10 : 8'd0;
            P_STEP100: return (c >= 640) ? 8'd100 : 8'd0;
            P_FALL10:  return (c < 640) ? 8'd10 : 8'd0;
            P_HORIZ:   return (row == 0) ? 8'd0 : 8'd10;
            P_CORNER:  return (row == 2 && c >= 640) ? 8'd10 : 8'd0;
            P_STEP30:  return (c >= 640) ? 8'd30 : 8'd0;
            P_STEP40:  return (c >= 640) ? 8'd40 : 8'd0;
            default:   return 8'd0;
        endcase
    endfunction

    // Hand-derived |Gx|+|Gy| for the window ending at column c
    function automatic int mag(input int pat, input int c);
        bit edge_col;
        edge_col = (c == 640) || (c == 641);
        case (pat)
            P_FLAT:    return 0;
            P_STEP10:  return edge_col ? 40 : 0;
            P_STEP100: return edge_col ? 400 : 0;
            P_FALL10:  return edge_col ? 40 : 0;
            P_HORIZ:   return 40;
            P_CORNER:  return (c < 640) ? 0 : ((c == 640) ? 20 : 40);
            P_STEP30:  return edge_col ? 120 : 0;
            P_STEP40:  return edge_col ? 160 : 0;
            default:   return 0;
        endcase
    endfunction

    function automatic logic [7:0] xform(input int m);
`ifdef SOBEL_THRESH_EN
        return (m >= THRESH) ? 8'd255 : 8'd0;
`else
        return (m > 255) ? 8'd255 : 8'(m);
`endif
    endfunction

    task automatic drive(input logic hs, input logic vs, input logic de,
                         input logic [23:0] col, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        e = exp_q.pop_front();
        check_val("o_hsync", o_hsync, e.hs);
        check_val("o_vsync", o_vsync, e.vs);
        check_val("o_de", o_de, e.de);
        check_val("o_data", o_data, e.data);
        i_hsync = hs;
        i_vsync = vs;
        i_de    = de;
        i_col   = col;
        e.hs = hs;
        e.vs = vs;
        e.de = de;
        e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic logic [23:0] build_col(input int pat, input int c);
        return {pix(pat, 0, c), pix(pat, 1, c), pix(pat, 2, c)};
    endfunction

    task automatic send_pixels(input int pat, input bit valid, input int ncols);
        logic [7:0] d;
        for (int c = 0; c < ncols; c++) begin
            d = (valid && c >= 2) ? xform(mag(pat, c)) : 8'd0;
            drive(1'b0, 1'b0, 1'b1, build_col(pat, c), d);
        end
    endtask

    task automatic blanking();
        for (int b = 0; b < 8; b++) begin
            drive((b >= 2 && b < 5), 1'b0, 1'b0, 24'd0, 8'd0);
        end
    endtask

    task automatic send_line(input int pat, input bit valid);
        send_pixels(pat, valid, IMG_W);
        blanking();
    endtask

    task automatic frame_start();
        for (int b = 0; b < 6; b++) begin
            drive(1'b0, (b < 3), 1'b0, 24'd0, 8'd0);
        end
    endtask

    task automatic reset_queue();
        exp_t z;
        z = '0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(z);
    endtask

    initial begin
        nrst    = 1'b1;
        i_hsync = 1'b0;
        i_vsync = 1'b0;
        i_de    = 1'b0;
        i_col   = 24'd0;
        reset_queue();
        #1 nrst = 1'b0;
        #2;
        check_val("rst_hsync", o_hsync, 0);
        check_val("rst_vsync", o_vsync, 0);
        check_val("rst_de", o_de, 0);
        check_val("rst_data", o_data, 0);
        @(negedge clk);
        nrst = 1'b1;

        // First frame: two warm-up lines must stay blank, then the test lines
        frame_start();
        send_line(P_STEP100, 1'b0);
        send_line(P_HORIZ, 1'b0);
        send_line(P_FLAT, 1'b1);
        send_line(P_STEP10, 1'b1);
        send_line(P_STEP100, 1'b1);
        send_line(P_FALL10, 1'b1);
        send_line(P_HORIZ, 1'b1);
        send_line(P_CORNER, 1'b1);
        send_line(P_STEP30, 1'b1);
        send_line(P_STEP40, 1'b1);

        // Asynchronous reset in the middle of a line with non-zero output
        send_pixels(P_HORIZ, 1'b1, 100);
        #2 nrst = 1'b0;
        #1;
        check_val("async_hsync", o_hsync, 0);
        check_val("async_vsync", o_vsync, 0);
        check_val("async_de", o_de, 0);
        check_val("async_data", o_data, 0);
        reset_queue();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 24'd0, 8'd0);
        nrst = 1'b1;

        // Partial line before any frame start: data must stay blank
        send_pixels(P_STEP100, 1'b0, 700);
        blanking();
        frame_start();
        send_line(P_STEP10, 1'b0);
        send_line(P_STEP10, 1'b0);
        send_line(P_STEP10, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, 24'd0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
